// File: rtl/fft_twiddle_streamer_pkg.sv
// rtl/fft_twiddle_streamer_pkg.sv - shared FFT types for the twiddle streamer.
package fft_twiddle_streamer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int MIN_FFT_SIZE = 4;

endpackage

// File: rtl/fft_twiddle_index_ctr.sv
// rtl/fft_twiddle_index_ctr.sv - butterfly index k, stage shift, and last-beat detection.
module fft_twiddle_index_ctr #(
  parameter int LOG2N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LOG2N-1:0] stage,
  input  logic             advance,
  output logic [LOG2N-2:0] k,
  output logic [LOG2N-1:0] j,
  output logic             last
);

  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam logic [KW-1:0] K_ALL_ONES = '1;

  logic [KW-1:0] k_q;
  logic [SW-1:0] shift_q;

  // shift_q = LOG2N-1-s; its reset value corresponds to stage 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q     <= '0;
      shift_q <= SW'(LOG2N - 1);
    end else if (load) begin
      k_q     <= '0;
      shift_q <= SW'(LOG2N - 1) - SW'(stage);
    end else if (advance) begin
      k_q <= last ? '0 : k_q + 1'b1;
    end
  end

  assign k    = k_q;
  assign j    = {1'b0, k_q} << shift_q;
  assign last = (k_q == (K_ALL_ONES >> shift_q));

endmodule

// File: rtl/fft_twiddle_streamer.sv
// rtl/fft_twiddle_streamer.sv - streams the twiddle factors of one FFT stage per request,
// looked up from a caller-supplied full-period sine table.
module fft_twiddle_streamer
  import fft_twiddle_streamer_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int SIZE_FFT   = 256,
  localparam int LOG2N     = $clog2(SIZE_FFT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] sine_wave_in [SIZE_FFT],
  input  logic [LOG2N-1:0]     recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_real,
  output logic [BIT_WIDTH-1:0] send_imag,
  output logic [LOG2N-2:0]     send_idx,
  output logic                 send_last,
  output logic                 send_val,
  input  logic                 send_rdy
);

  if (SIZE_FFT < MIN_FFT_SIZE || DECIMAL_PT >= BIT_WIDTH) begin : g_bad_params
    $error("fft_twiddle_streamer: unsupported SIZE_FFT/DECIMAL_PT");
  end

  localparam logic [LOG2N-1:0] MAX_STAGE = LOG2N'(LOG2N - 1);

  state_t           state;
  logic             rdy_q;
  logic             val_q;
  logic [LOG2N-1:0] stage_sat;
  logic             load;
  logic             advance;
  logic [LOG2N-2:0] k;
  logic [LOG2N-1:0] j;
  logic             last;
  logic [LOG2N-1:0] real_idx;
  logic [LOG2N-1:0] imag_idx;

  assign stage_sat = (recv_msg > MAX_STAGE) ? MAX_STAGE : recv_msg;
  assign load      = (state == IDLE) && recv_val;
  assign advance   = val_q && send_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rdy_q <= 1'b1;
      val_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (recv_val) begin
          state <= STREAM;
          rdy_q <= 1'b0;
          val_q <= 1'b1;
        end
        STREAM: if (send_rdy && last) begin
          state <= IDLE;
          rdy_q <= 1'b1;
          val_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          val_q <= 1'b0;
        end
      endcase
    end
  end

  fft_twiddle_index_ctr #(
    .LOG2N(LOG2N)
  ) u_index_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .stage  (stage_sat),
    .advance(advance),
    .k      (k),
    .j      (j),
    .last   (last)
  );

  // Handshake flags are masked so the reset cycle itself shows neither ready nor valid.
  assign recv_rdy = rdy_q && !reset;
  assign send_val = val_q && !reset;

  // cos(x) = sin(x + pi/2) and -sin(x) = sin(x + pi): index offsets wrap modulo N.
  assign real_idx = j + LOG2N'(SIZE_FFT / 4);
  assign imag_idx = j + LOG2N'(SIZE_FFT / 2);

  assign send_real = send_val ? sine_wave_in[real_idx] : '0;
  assign send_imag = send_val ? sine_wave_in[imag_idx] : '0;
  assign send_idx  = send_val ? k : '0;
  assign send_last = send_val && last;

endmodule

// File: tb/tb_fft_twiddle_streamer.sv
// tb/tb_fft_twiddle_streamer.sv - scoreboard bench for fft_twiddle_streamer.
module tb_fft_twiddle_streamer;

  localparam int BW = 32;
  localparam int N  = 256;
  localparam int LG = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] sine_wave_in [N];
  logic [LG-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_real;
  logic [BW-1:0] send_imag;
  logic [LG-2:0] send_idx;
  logic          send_last;
  logic          send_val;
  logic          send_rdy;

  typedef struct {
    int re;
    int im;
    int idx;
    bit last;
  } beat_t;

  int    tbl [N];
  beat_t exp_q [$];
  beat_t got_q [$];
  beat_t ref7  [$];
  int    checks = 0;
  int    errors = 0;
  bit    rand_rdy = 1'b0;

  fft_twiddle_streamer #(
    .BIT_WIDTH (BW),
    .DECIMAL_PT(16),
    .SIZE_FFT  (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sine_wave_in(sine_wave_in),
    .recv_msg    (recv_msg),
    .recv_val    (recv_val),
    .recv_rdy    (recv_rdy),
    .send_real   (send_real),
    .send_imag   (send_imag),
    .send_idx    (send_idx),
    .send_last   (send_last),
    .send_val    (send_val),
    .send_rdy    (send_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: stage s has 2^s twiddles W_N^(k*N/2^(s+1)), read from the sine table.
  task automatic model_push(input int s, input int max_beats);
    int s_eff, cnt, j;
    beat_t b;
    s_eff = (s > LG - 1) ? LG - 1 : s;
    cnt   = 2 ** s_eff;
    for (int k = 0; k < cnt && k < max_beats; k++) begin
      j      = k * (N / (2 * cnt));
      b.re   = tbl[(j + N / 4) % N];
      b.im   = tbl[(j + N / 2) % N];
      b.idx  = k;
      b.last = (k == cnt - 1);
      exp_q.push_back(b);
    end
  endtask

  beat_t prev;
  bit    prev_stall = 1'b0;

  always @(negedge clk) begin
    beat_t cur, e;
    cur.re   = $signed(send_real);
    cur.im   = $signed(send_imag);
    cur.idx  = int'(send_idx);
    cur.last = send_last;
    if (!send_val)
      check("zero_when_invalid", int'(send_real != 0 || send_imag != 0 || send_idx != 0 || send_last), 0);
    if (!reset && send_val && prev_stall) begin
      check("hold_real", cur.re, prev.re);
      check("hold_imag", cur.im, prev.im);
      check("hold_idx", cur.idx, prev.idx);
      check("hold_last", int'(cur.last), int'(prev.last));
    end
    if (!reset && send_val && send_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx %0d, expected no beat", cur.idx);
      end else begin
        e = exp_q.pop_front();
        check("beat_real", cur.re, e.re);
        check("beat_imag", cur.im, e.im);
        check("beat_idx", cur.idx, e.idx);
        check("beat_last", int'(cur.last), int'(e.last));
      end
      got_q.push_back(cur);
    end
    prev_stall = !reset && send_val && !send_rdy;
    prev       = cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) send_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_drain(input bit garbage);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      if (garbage && exp_q.size() > 1) begin
        recv_val = 1'($urandom_range(0, 1));
        recv_msg = LG'($urandom);
      end else begin
        recv_val = 1'b0;
      end
      tick();
      n++;
    end
    recv_val = 1'b0;
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_stage(input int s, input bit garbage);
    int n;
    n = 0;
    while (recv_rdy !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("recv_rdy_before_req", int'(recv_rdy), 1);
    got_q.delete();
    model_push(s, N);
    recv_msg = LG'(s);
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    check("latency_send_val", int'(send_val), 1);
    check("busy_recv_rdy", int'(recv_rdy), 0);
    wait_drain(garbage);
    check("idle_after_last_rdy", int'(recv_rdy), 1);
    check("idle_after_last_val", int'(send_val), 0);
  endtask

  initial begin
    int nlast, diff;
    for (int i = 0; i < N; i++) begin
      tbl[i]          = $rtoi($sin(2.0 * 3.141592653589793 * i / N) * 65536.0);
      sine_wave_in[i] = tbl[i];
    end
    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b1;
    tick();
    check("reset_recv_rdy", int'(recv_rdy), 0);
    check("reset_send_val", int'(send_val), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_recv_rdy", int'(recv_rdy), 1);
    check("post_reset_send_val", int'(send_val), 0);

    do_stage(0, 1'b0);
    check("s0_beats", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("s0_real", got_q[0].re, 65536);
      check("s0_imag", got_q[0].im, 0);
      check("s0_idx", got_q[0].idx, 0);
      check("s0_last", int'(got_q[0].last), 1);
    end

    do_stage(1, 1'b0);
    check("s1_beats", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("s1_k0_real", got_q[0].re, 65536);
      check("s1_k0_imag", got_q[0].im, 0);
      check("s1_k0_last", int'(got_q[0].last), 0);
      check("s1_k1_real", got_q[1].re, 0);
      check("s1_k1_imag", got_q[1].im, -65536);
      check("s1_k1_last", int'(got_q[1].last), 1);
    end

    do_stage(7, 1'b0);
    check("s7_beats", got_q.size(), 128);
    if (got_q.size() == 128) begin
      check("s7_k1_real", got_q[1].re, 65516);
      check("s7_k1_imag", got_q[1].im, -1608);
      check("s7_k64_real", got_q[64].re, 0);
      check("s7_k64_imag", got_q[64].im, -65536);
      nlast = 0;
      foreach (got_q[i]) nlast += int'(got_q[i].last);
      check("s7_last_count", nlast, 1);
      check("s7_last_k127", int'(got_q[127].last), 1);
    end
    ref7 = got_q;

    do_stage(9, 1'b0);
    check("s9_beats", got_q.size(), 128);
    diff = 0;
    foreach (got_q[i])
      if (i < ref7.size() && (got_q[i].re != ref7[i].re || got_q[i].im != ref7[i].im ||
          got_q[i].idx != ref7[i].idx || got_q[i].last != ref7[i].last)) diff++;
    check("s9_matches_s7", diff, 0);

    // Stage 2, consumer stalls for three cycles while k=1 is presented.
    got_q.delete();
    model_push(2, N);
    recv_msg = LG'(2);
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    tick();
    send_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_real", $signed(send_real), 46340);
      check("stall_imag", $signed(send_imag), -46340);
      check("stall_idx", int'(send_idx), 1);
      tick();
    end
    send_rdy = 1'b1;
    wait_drain(1'b0);
    check("stall_beats", got_q.size(), 4);

    // Reset while k=5 of stage 7 is on the output.
    got_q.delete();
    model_push(7, 5);
    recv_msg = LG'(7);
    recv_val = 1'b1;
    tick();
    recv_val = 1'b0;
    repeat (5) tick();
    check("pre_reset_idx", int'(send_idx), 5);
    reset = 1'b1;
    #1;
    check("in_reset_send_val", int'(send_val), 0);
    check("in_reset_recv_rdy", int'(recv_rdy), 0);
    tick();
    reset = 1'b0;
    #1;
    check("after_reset_send_val", int'(send_val), 0);
    check("after_reset_recv_rdy", int'(recv_rdy), 1);
    check("after_reset_beats", got_q.size(), 5);
    check("after_reset_pending", exp_q.size(), 0);
    exp_q.delete();
    do_stage(0, 1'b0);
    check("post_reset_s0_beats", got_q.size(), 1);
    if (got_q.size() == 1) check("post_reset_s0_real", got_q[0].re, 65536);

    // Random stages, random backpressure, stray requests during streaming.
    rand_rdy = 1'b1;
    for (int t = 0; t < 25; t++) do_stage(int'($urandom_range(0, 9)), 1'b1);
    rand_rdy = 1'b0;
    send_rdy = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
